// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter sharing one add/sub datapath
// between NUM_REQ requesters through an issue and a response register.

module adder #(
  parameter int BITWIDTH = 16
) (
  input  logic [BITWIDTH-1:0] a,
  input  logic [BITWIDTH-1:0] b,
  input  logic                sub,
  output logic [BITWIDTH-1:0] sum
);

  assign sum = sub ? a - b : a + b;

endmodule

module adder_arbiter #(
  parameter int BITWIDTH = 16,
  parameter int NUM_REQ  = 4,
  parameter int ID_W     = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*BITWIDTH-1:0]  req_a,
  input  logic [NUM_REQ*BITWIDTH-1:0]  req_b,
  input  logic [NUM_REQ-1:0]           req_sub,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [BITWIDTH-1:0]          rsp_result,
  output logic [ID_W-1:0]              rsp_id
);

  logic                s1_valid;
  logic [BITWIDTH-1:0] s1_a;
  logic [BITWIDTH-1:0] s1_b;
  logic                s1_sub;
  logic [ID_W-1:0]     s1_id;
  logic [ID_W-1:0]     rr_ptr;

  logic                s2_adv;
  logic                s1_adv;
  logic                s1_free;
  logic                gnt;
  logic [ID_W-1:0]     gnt_id;
  logic [ID_W-1:0]     nxt_ptr;
  logic [BITWIDTH-1:0] sum;
  int                  idx;

  assign s2_adv  = !rsp_valid || rsp_ready;
  assign s1_adv  = s1_valid && s2_adv;
  assign s1_free = !s1_valid || s2_adv;

  // First valid requester at or above rr_ptr, wrapping around.
  always_comb begin
    req_ready = '0;
    gnt       = 1'b0;
    gnt_id    = '0;
    idx       = 0;
    if (s1_free && !rst) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (int'(rr_ptr) + k) % NUM_REQ;
        if (!gnt && req_valid[idx]) begin
          gnt    = 1'b1;
          gnt_id = ID_W'(idx);
        end
      end
      if (gnt) req_ready[gnt_id] = 1'b1;
    end
  end

  always_comb begin
    nxt_ptr = gnt_id + 1'b1;
    if (int'(gnt_id) == NUM_REQ - 1) nxt_ptr = '0;
  end

  adder #(.BITWIDTH(BITWIDTH)) u_adder (
    .a   (s1_a),
    .b   (s1_b),
    .sub (s1_sub),
    .sum (sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_sub     <= 1'b0;
      s1_id      <= '0;
      rr_ptr     <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_id     <= '0;
    end else begin
      if (s1_free) begin
        s1_valid <= gnt;
        if (gnt) begin
          s1_a   <= req_a[int'(gnt_id)*BITWIDTH +: BITWIDTH];
          s1_b   <= req_b[int'(gnt_id)*BITWIDTH +: BITWIDTH];
          s1_sub <= req_sub[gnt_id];
          s1_id  <= gnt_id;
          rr_ptr <= nxt_ptr;
        end
      end
      if (s1_adv) begin
        rsp_valid  <= 1'b1;
        rsp_result <= sum;
        rsp_id     <= s1_id;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule
